// File: rtl/vga_grid_scanner_if.sv
// Display-side bundle of the raster scanner: scan coordinates out, ROM colour
// back in, registered VGA signals out.
interface vga_grid_scanner_if;
  logic [5:0]  o_game_x;
  logic [5:0]  o_game_y;
  logic [3:0]  o_grid_x;
  logic [3:0]  o_grid_y;
  logic        o_active;
  logic        o_frame_start;
  logic [23:0] i_rgb;
  logic [23:0] o_vga_rgb;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_blank_n;

  modport master (
    output o_game_x, o_game_y, o_grid_x, o_grid_y, o_active, o_frame_start,
    output o_vga_rgb, o_hsync, o_vsync, o_blank_n,
    input  i_rgb
  );

  modport slave (
    input  o_game_x, o_game_y, o_grid_x, o_grid_y, o_active, o_frame_start,
    input  o_vga_rgb, o_hsync, o_vsync, o_blank_n,
    output i_rgb
  );
endinterface

// File: rtl/vga_grid_scanner.sv
// VGA raster timing with incremental game-cell coordinates; registers the
// combinational ROM colour and keeps sync/blank aligned with it.
module vga_grid_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CELL     = 10
) (
  input logic                i_clk,
  input logic                i_rst,
  vga_grid_scanner_if.master bus
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [HW-1:0] h_cnt_p0;
  logic [VW-1:0] v_cnt_p0;
  logic [3:0]    grid_x_p0;
  logic [3:0]    grid_y_p0;
  logic [5:0]    game_x_p0;
  logic [5:0]    game_y_p0;
  logic          h_last;
  logic          v_last;
  logic          h_cell_run;
  logic          v_cell_run;
  logic          active_p0;
  logic          hsync_p0;
  logic          vsync_p0;

  logic [23:0]   rgb_p1;
  logic          hsync_p1;
  logic          vsync_p1;
  logic          blank_n_p1;

  assign h_last     = (h_cnt_p0 == HW'(H_TOTAL - 1));
  assign v_last     = (v_cnt_p0 == VW'(V_TOTAL - 1));
  // Cell counters advance only up to the last visible pixel/line, then clear
  // so they read 0 through the blanking interval.
  assign h_cell_run = (h_cnt_p0 < HW'(H_ACTIVE - 1));
  assign v_cell_run = (v_cnt_p0 < VW'(V_ACTIVE - 1));
  assign active_p0  = (h_cnt_p0 < HW'(H_ACTIVE)) && (v_cnt_p0 < VW'(V_ACTIVE));
  assign hsync_p0   = !((h_cnt_p0 >= HW'(HS_START)) && (h_cnt_p0 < HW'(HS_END)));
  assign vsync_p0   = !((v_cnt_p0 >= VW'(VS_START)) && (v_cnt_p0 < VW'(VS_END)));

  // Stage 0: raster and cell counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt_p0  <= '0;
      v_cnt_p0  <= '0;
      grid_x_p0 <= '0;
      game_x_p0 <= '0;
      grid_y_p0 <= '0;
      game_y_p0 <= '0;
    end else begin
      h_cnt_p0 <= h_last ? '0 : h_cnt_p0 + HW'(1);
      if (h_cell_run) begin
        if (grid_x_p0 == 4'(CELL - 1)) begin
          grid_x_p0 <= '0;
          game_x_p0 <= game_x_p0 + 6'd1;
        end else begin
          grid_x_p0 <= grid_x_p0 + 4'd1;
        end
      end else begin
        grid_x_p0 <= '0;
        game_x_p0 <= '0;
      end
      if (h_last) begin
        v_cnt_p0 <= v_last ? '0 : v_cnt_p0 + VW'(1);
        if (v_cell_run) begin
          if (grid_y_p0 == 4'(CELL - 1)) begin
            grid_y_p0 <= '0;
            game_y_p0 <= game_y_p0 + 6'd1;
          end else begin
            grid_y_p0 <= grid_y_p0 + 4'd1;
          end
        end else begin
          grid_y_p0 <= '0;
          game_y_p0 <= '0;
        end
      end
    end
  end

  // Stage 1: registered colour with matching sync and blank
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb_p1     <= '0;
      blank_n_p1 <= 1'b0;
      hsync_p1   <= 1'b1;
      vsync_p1   <= 1'b1;
    end else begin
      rgb_p1     <= active_p0 ? bus.i_rgb : '0;
      blank_n_p1 <= active_p0;
      hsync_p1   <= hsync_p0;
      vsync_p1   <= vsync_p0;
    end
  end

  assign bus.o_game_x      = game_x_p0;
  assign bus.o_game_y      = game_y_p0;
  assign bus.o_grid_x      = grid_x_p0;
  assign bus.o_grid_y      = grid_y_p0;
  assign bus.o_active      = active_p0;
  assign bus.o_frame_start = (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
  assign bus.o_vga_rgb     = rgb_p1;
  assign bus.o_hsync       = hsync_p1;
  assign bus.o_vsync       = vsync_p1;
  assign bus.o_blank_n     = blank_n_p1;
endmodule

// File: doc/vga_grid_scanner.md
# vga_grid_scanner

Raster front end for the display path. It generates 640x480 VGA timing from free-running pixel counters and converts the scan position into game-cell coordinates (`game_x`/`game_y`) and intra-cell pixel offsets (`grid_x`/`grid_y`), which feed the per-object display ROMs such as the tank sprite blocks. It then registers the combinational RGB those ROMs return into the VGA output, with sync and blank delayed to stay pixel-aligned.

## Interface

Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- `CELL`, 10: pixels per game cell, in both axes.

Ports:
- `i_clk`, input, 1: pixel clock. One pixel per cycle, no enable.
- `i_rst`, input, 1: synchronous, active-high reset.
- `o_game_x`, output, 6: cell column, 0..63.
- `o_game_y`, output, 6: cell row, 0..47.
- `o_grid_x`, output, 4: pixel within cell, 0..CELL-1.
- `o_grid_y`, output, 4: line within cell, 0..CELL-1.
- `o_active`, output, 1: current stage-0 coordinates are inside the visible area.
- `o_frame_start`, output, 1: one-cycle pulse at h=0, v=0 (stage 0).
- `i_rgb`, input, 24: pixel colour computed combinationally from the stage-0 coordinates.
- `o_vga_rgb`, output, 24: registered colour, stage 1.
- `o_hsync`, output, 1: active-low horizontal sync, stage 1.
- `o_vsync`, output, 1: active-low vertical sync, stage 1.
- `o_blank_n`, output, 1: high during visible pixels, stage 1.

## Operation

- Counters:
  - `h_cnt` runs 0..H_TOTAL-1 (800), then wraps to 0.
  - `v_cnt` increments when `h_cnt` wraps and runs 0..V_TOTAL-1 (525), then wraps.
  - Visible region: `h_cnt` < H_ACTIVE and `v_cnt` < V_ACTIVE.
- Cell counters are incremental; no divider or multiplier is allowed.
  - Horizontal: while `h_cnt` < H_ACTIVE, `grid_x` increments each cycle. At CELL-1 it wraps to 0 and `game_x` increments.
  - At `h_cnt` = H_TOTAL-1, `grid_x` and `game_x` reload to 0. Outside the visible columns they hold 0.
  - Vertical: on each line wrap while `v_cnt` < V_ACTIVE, `grid_y` increments. At CELL-1 it wraps to 0 and `game_y` increments.
  - At the frame wrap, `grid_y` and `game_y` reload to 0. They hold 0 during vertical blank.
- Coordinates are the register outputs themselves (stage 0), so each value is stable for one full pixel.
- Sync windows:
  - hsync is low for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is low for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Stage 1, every cycle:
  - `o_vga_rgb` <= `i_rgb` when stage-0 is active, otherwise 0.
  - `o_blank_n` <= stage-0 active.
  - `o_hsync` and `o_vsync` <= their stage-0 values.
- `o_frame_start` is combinational from the counters: (`h_cnt`==0 && `v_cnt`==0). Game logic uses it to update object positions before the first visible pixel.
- Width rules: `game_x` never exceeds 63 with the default parameters. Parameter sets where H_ACTIVE/CELL > 64 or V_ACTIVE/CELL > 64 are unsupported.

## Timing

- Reset values:
  - All counters 0.
  - `o_vga_rgb` = 0, `o_blank_n` = 0, `o_hsync` = 1, `o_vsync` = 1.
  - `o_active` = 1 and `o_frame_start` = 1 in the reset cycle's output, since the counters sit at 0,0.
- First cycle after `i_rst` deasserts: `h_cnt`=0, `v_cnt`=0, coordinates (0,0,0,0), `o_frame_start` high.
- Latency: `i_rgb` sampled in cycle N appears on `o_vga_rgb` in cycle N+1, together with that pixel's sync and blank.
- Reset mid-frame: the next cycle restarts at 0,0. There is no partial-line recovery.
- Line wrap and frame wrap coinciding (h=799, v=524): all six counters reload to 0 in the same edge.

## Test plan

- Reset then 1 cycle: `o_frame_start`=1 and coordinates all 0. One cycle later, `o_vga_rgb`=0, `o_hsync`=1, `o_vsync`=1.
- Drive `i_rgb` = 24'hFF0000 constant:
  - `o_blank_n`=1 and `o_vga_rgb`=FF0000 for exactly 640 cycles per line, starting one cycle after `h_cnt`=0.
  - `o_vga_rgb`=0 for the other 160.
- At `h_cnt`=9: `grid_x`=9, `game_x`=0. At `h_cnt`=10: `grid_x`=0, `game_x`=1. At `h_cnt`=639: `game_x`=63, `grid_x`=9. At `h_cnt`=640: both 0.
- Line 479, last visible pixel: `game_y`=47, `grid_y`=9. Line 480: both 0 with `o_active`=0.
- Measure `o_hsync`: low 96 cycles, period 800. Measure `o_vsync`: low 2 lines (1600 cycles), period 525 lines. `o_frame_start` period 420000 cycles.
- Assert `i_rst` at h=300, v=200: the next cycle shows counters 0,0 and `o_frame_start`=1, with stage-1 outputs at reset values.
